// File: rtl/sky130_gpio_pad_ctrl_if.sv
// Serial configuration port of sky130_gpio_pad_ctrl: host load strobes plus busy/done/readback.
interface sky130_gpio_pad_ctrl_if;
  logic cfg_start;
  logic cfg_bit_valid;
  logic cfg_sdi;
  logic cfg_sdo;
  logic cfg_busy;
  logic cfg_done;

  modport master (
    output cfg_start, cfg_bit_valid, cfg_sdi,
    input  cfg_sdo, cfg_busy, cfg_done
  );

  modport slave (
    input  cfg_start, cfg_bit_valid, cfg_sdi,
    output cfg_sdo, cfg_busy, cfg_done
  );
endinterface

// File: rtl/sky130_gpio_pad_ctrl.sv
// Core-side control for one sky130 GPIOv2 pad: serial config load, settle tristate, IN synchroniser.
// Optional feature macro: GPIO_CTRL_READBACK_EN (old config shifted out on cfg_sdo during a load).
module sky130_gpio_pad_ctrl #(
  parameter int unsigned CFG_W       = 13,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   nreset,
  sky130_gpio_pad_ctrl_if.slave  cfg,
  input  logic                   core_out,
  input  logic                   core_oe,
  output logic                   core_in,
  input  logic                   pad_in,
  output logic                   pad_out,
  output logic                   pad_oe_n,
  output logic [2:0]             pad_dm,
  output logic                   pad_inp_dis,
  output logic                   pad_ib_mode_sel,
  output logic                   pad_vtrip_sel,
  output logic                   pad_slow,
  output logic                   pad_hld_ovr,
  output logic                   pad_analog_en,
  output logic                   pad_analog_sel,
  output logic                   pad_analog_pol
);

  localparam int unsigned CNT_W = $clog2(CFG_W + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2,
    APPLY  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [SET_W-1:0]   set_cnt, set_cnt_nxt;
  logic [CFG_W-1:0]   shadow, shadow_nxt;
  logic [CFG_W-1:0]   act, act_nxt;
  logic               busy_q, done_q;
  logic [SYNC_STAGES-1:0] sync_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      set_cnt <= '0;
      shadow  <= '0;
      act     <= CFG_W'(1);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      set_cnt <= set_cnt_nxt;
      shadow  <= shadow_nxt;
      act     <= act_nxt;
      busy_q  <= (state_nxt != IDLE);
      done_q  <= (state_nxt == APPLY);
    end
  end

  // Next-state logic; a restart in SHIFT wins over a same-cycle bit
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    set_cnt_nxt = set_cnt;
    shadow_nxt  = shadow;
    act_nxt     = act;
    case (state)
      IDLE: begin
        if (cfg.cfg_start) begin
          state_nxt   = SHIFT;
          bit_cnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (cfg.cfg_start) begin
          bit_cnt_nxt = '0;
        end else if (cfg.cfg_bit_valid) begin
          shadow_nxt = {cfg.cfg_sdi, shadow[CFG_W-1:1]};
          if (bit_cnt == CNT_W'(CFG_W - 1)) begin
            state_nxt   = SETTLE;
            set_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
      SETTLE: begin
        if (set_cnt == SET_W'(SETTLE_CYC - 1)) begin
          state_nxt = APPLY;
        end else begin
          set_cnt_nxt = set_cnt + SET_W'(1);
        end
      end
      APPLY: begin
        act_nxt   = shadow;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef GPIO_CTRL_READBACK_EN
  logic [CFG_W-1:0] rb_q;
  logic             rb_load, rb_shift;

  assign rb_load  = (state == IDLE) && cfg.cfg_start;
  assign rb_shift = (state == SHIFT) && !cfg.cfg_start && cfg.cfg_bit_valid;

  // Old config streams out LSB first while the new one streams in
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rb_q <= '0;
    end else if (rb_load) begin
      rb_q <= act;
    end else if (rb_shift) begin
      rb_q <= {1'b0, rb_q[CFG_W-1:1]};
    end
  end

  assign cfg.cfg_sdo = rb_q[0];
`else
  assign cfg.cfg_sdo = 1'b0;
`endif

  // Pad IN synchroniser into the core clock domain
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
    end
  end

  assign core_in      = sync_q[SYNC_STAGES-1];
  assign cfg.cfg_busy = busy_q;
  assign cfg.cfg_done = done_q;

  // Pad pins track the active config; output is tristated throughout SETTLE
  assign pad_out         = act[11] ? act[12] : core_out;
  assign pad_oe_n        = (state == SETTLE) | ~(act[11] | core_oe);
  assign pad_dm          = act[2:0];
  assign pad_inp_dis     = act[3];
  assign pad_ib_mode_sel = act[4];
  assign pad_vtrip_sel   = act[5];
  assign pad_slow        = act[6];
  assign pad_hld_ovr     = act[7];
  assign pad_analog_en   = act[8];
  assign pad_analog_sel  = act[9];
  assign pad_analog_pol  = act[10];

endmodule
